// File: rtl/overcurrent_pkg.sv
// Shared types and default thresholds for the over-current monitor.
package overcurrent_pkg;
   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_PENDING = 2'd2,
      ST_TRIPPED = 2'd3
   } oc_state_t;

   localparam int DEF_N_CH         = 4;
   localparam int DEF_DATA_W       = 12;
   localparam int DEF_CURRENT_MAX  = 2500;
   localparam int DEF_CURRENT_CLR  = 2300;
   localparam int DEF_TRIP_CYCLES  = 5000;
   localparam int DEF_RETRY_CYCLES = 50000;
endpackage

// File: rtl/overcurrent_channel.sv
// One channel: hysteresis trip qualification FSM with latched load-off.
// Optional auto-retry from TRIPPED when OVERCURRENT_AUTO_RETRY_EN is defined.
module overcurrent_channel
   import overcurrent_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CURRENT_MAX  = DEF_CURRENT_MAX,
   parameter int CURRENT_CLR  = DEF_CURRENT_CLR,
`ifdef OVERCURRENT_AUTO_RETRY_EN
   parameter int RETRY_CYCLES = DEF_RETRY_CYCLES,
`endif
   parameter int TRIP_CYCLES  = DEF_TRIP_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   input  logic              fault_clear,
   output logic              current_high,
   output logic              high_nxt,
   output logic              pending
);
   localparam int CNT_W = $clog2(TRIP_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRIP_CYCLES);

   oc_state_t        state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [31:0]      sample_ext;
   logic             over, clear, retry_done;

   assign sample_ext = 32'(sample);
   assign over  = sample_valid && (sample_ext > 32'(CURRENT_MAX));
   assign clear = sample_valid && (sample_ext < 32'(CURRENT_CLR));

`ifdef OVERCURRENT_AUTO_RETRY_EN
   localparam int RTY_W = $clog2(RETRY_CYCLES + 1);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(RETRY_CYCLES);
   logic [RTY_W-1:0] retry_cnt, retry_nxt;

   // Counts cycles spent in TRIPPED; a clear request restarts the wait.
   always_comb begin
      retry_nxt = '0;
      if (state == ST_TRIPPED && !fault_clear)
         retry_nxt = (retry_cnt == RTY_MAX) ? retry_cnt : retry_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) retry_cnt <= '0;
      else        retry_cnt <= retry_nxt;

   assign retry_done = (retry_cnt == RTY_MAX);
`else
   assign retry_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_INIT;
         count        <= '0;
         current_high <= 1'b1;
      end else begin
         state        <= state_nxt;
         count        <= count_nxt;
         current_high <= high_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      unique case (state)
         ST_INIT:
            if (sample_valid && !over) state_nxt = ST_ARMED;
         ST_ARMED:
            if (over) begin
               count_nxt = CNT_W'(1);
               state_nxt = (CNT_MAX == CNT_W'(1)) ? ST_TRIPPED : ST_PENDING;
            end
         ST_PENDING:
            // Any valid non-over sample, hysteresis band included, restarts qualification.
            if (over) begin
               count_nxt = (count == CNT_MAX) ? count : count + 1'b1;
               if (count == CNT_MAX - 1'b1) state_nxt = ST_TRIPPED;
            end else if (sample_valid) begin
               count_nxt = '0;
               state_nxt = ST_ARMED;
            end
         ST_TRIPPED:
            if (clear && (fault_clear || retry_done)) begin
               count_nxt = '0;
               state_nxt = ST_ARMED;
            end
         default: begin
            state_nxt = ST_INIT;
            count_nxt = '0;
         end
      endcase
   end

   always_comb begin
      high_nxt = (state_nxt == ST_INIT) || (state_nxt == ST_TRIPPED);
      pending  = (state == ST_PENDING);
   end
endmodule

// File: rtl/overcurrent_monitor.sv
// N_CH-channel over-current monitor; auto-retry enabled by OVERCURRENT_AUTO_RETRY_EN.
module overcurrent_monitor
   import overcurrent_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CURRENT_MAX  = DEF_CURRENT_MAX,
   parameter int CURRENT_CLR  = DEF_CURRENT_CLR,
   parameter int TRIP_CYCLES  = DEF_TRIP_CYCLES,
   parameter int RETRY_CYCLES = DEF_RETRY_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sample_valid,
   input  logic [N_CH*DATA_W-1:0] current_in,
   input  logic [N_CH-1:0]        fault_clear,
   output logic [N_CH-1:0]        current_high,
   output logic [N_CH-1:0]        pending,
   output logic                   any_fault
);
   logic [N_CH-1:0] high_nxt;

   if (CURRENT_CLR >= CURRENT_MAX || TRIP_CYCLES < 1 || RETRY_CYCLES < 1) begin : g_bad_cfg
      $error("overcurrent_monitor: invalid threshold/cycle parameters");
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      overcurrent_channel #(
         .DATA_W       (DATA_W),
         .CURRENT_MAX  (CURRENT_MAX),
         .CURRENT_CLR  (CURRENT_CLR),
`ifdef OVERCURRENT_AUTO_RETRY_EN
         .RETRY_CYCLES (RETRY_CYCLES),
`endif
         .TRIP_CYCLES  (TRIP_CYCLES)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .sample_valid (sample_valid),
         .sample       (current_in[g*DATA_W +: DATA_W]),
         .fault_clear  (fault_clear[g]),
         .current_high (current_high[g]),
         .high_nxt     (high_nxt[g]),
         .pending      (pending[g])
      );
   end

   // Built from next-state values so it tracks current_high on the same edge.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) any_fault <= 1'b1;
      else        any_fault <= |high_nxt;
endmodule

// File: tb/tb_overcurrent_monitor.sv
// Randomized + directed bench for overcurrent_monitor (default build, no auto-retry).
module tb_overcurrent_monitor;
   localparam int N    = 4;
   localparam int W    = 12;
   localparam int MAX  = 2500;
   localparam int CLR  = 2300;
   localparam int TRIP = 5000;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           sample_valid;
   logic [N*W-1:0] current_in;
   logic [N-1:0]   fault_clear, current_high, pending;
   logic           any_fault;

   overcurrent_monitor dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .current_in   (current_in),
      .fault_clear  (fault_clear),
      .current_high (current_high),
      .pending      (pending),
      .any_fault    (any_fault)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0;

   // Reference: "seen a safe sample yet", "latched trip", length of current over-run.
   bit m_ready[N];
   bit m_trip[N];
   int m_run[N];

   bit           vld;
   int           smp[N];
   logic [N-1:0] fclr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_ready[i] = 0; m_trip[i] = 0; m_run[i] = 0;
      end
   endfunction

   function automatic void model_step();
      for (int i = 0; i < N; i++) begin
         bit is_over, is_clear;
         is_over  = smp[i] > MAX;
         is_clear = smp[i] < CLR;
         if (!vld) continue;
         if (!m_ready[i]) begin
            if (!is_over) m_ready[i] = 1;
         end else if (m_trip[i]) begin
            if (fclr[i] && is_clear) begin m_trip[i] = 0; m_run[i] = 0; end
         end else if (is_over) begin
            m_run[i]++;
            if (m_run[i] >= TRIP) m_trip[i] = 1;
         end else begin
            m_run[i] = 0;
         end
      end
   endfunction

   task automatic check_outs(input string tag);
      logic [N-1:0] eh, ep;
      for (int i = 0; i < N; i++) begin
         eh[i] = !m_ready[i] || m_trip[i];
         ep[i] = m_ready[i] && !m_trip[i] && (m_run[i] > 0);
      end
      chk({tag, ".high"}, 32'(current_high), 32'(eh));
      chk({tag, ".pend"}, 32'(pending), 32'(ep));
      chk({tag, ".any"}, 32'(any_fault), 32'(|eh));
   endtask

   task automatic cyc(input string tag);
      sample_valid = vld;
      fault_clear  = fclr;
      for (int i = 0; i < N; i++) current_in[i*W +: W] = smp[i][W-1:0];
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outs(tag);
   endtask

   task automatic run(input string tag, input int n);
      for (int k = 0; k < n; k++) cyc(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pick[7];
      pick = '{0, 1000, 2299, 2300, 2500, 2501, 4095};
      vld = 0; fclr = '0;
      for (int i = 0; i < N; i++) smp[i] = 0;
      sample_valid = 0; fault_clear = '0; current_in = '0;
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outs("rst");
      rst_n = 1;

      run("init_hold", 2);
      // Over sample in INIT must not arm.
      vld = 1; for (int i = 0; i < N; i++) smp[i] = 3000;
      cyc("init_over");
      for (int i = 0; i < N; i++) smp[i] = 1000;
      cyc("arm");
      chk("arm.direct", 32'(current_high), 32'd0);

      // Channel 0 trips on exactly the TRIP-th over sample.
      smp[0] = 2501;
      run("ch0_pend", TRIP - 1);
      chk("ch0.pend_before", 32'(pending[0]), 32'd1);
      chk("ch0.high_before", 32'(current_high[0]), 32'd0);
      cyc("ch0_trip");
      chk("ch0.high_at", 32'(current_high[0]), 32'd1);
      chk("ch0.others", 32'(current_high[3:1]), 32'd0);

      // Channel 1: band sample at 2500 breaks the run.
      smp[1] = 2600;
      run("ch1_a", TRIP - 1);
      smp[1] = 2500;
      cyc("ch1_band");
      chk("ch1.band_pend", 32'(pending[1]), 32'd0);
      smp[1] = 2600;
      run("ch1_b", 10);
      chk("ch1.no_trip", 32'(current_high[1]), 32'd0);
      run("ch1_c", TRIP - 11);
      chk("ch1.still_armed", 32'(current_high[1]), 32'd0);
      cyc("ch1_trip");
      chk("ch1.trip", 32'(current_high[1]), 32'd1);

      // Channel 2: clear only honoured with a valid clear sample in the same cycle.
      smp[2] = 3000;
      run("ch2_trip", TRIP);
      smp[2] = 2400; fclr = 4'b0100;
      cyc("ch2_band_clr");
      chk("ch2.band_clr", 32'(current_high[2]), 32'd1);
      smp[2] = 2299; fclr = '0;
      cyc("ch2_no_memory");
      vld = 0; fclr = 4'b0100;
      cyc("ch2_invalid_clr");
      chk("ch2.invalid_clr", 32'(current_high[2]), 32'd1);
      vld = 1;
      cyc("ch2_clr");
      chk("ch2.cleared", 32'(current_high[2]), 32'd0);
      fclr = '0;

      // Channel 3: asynchronous reset mid-qualification.
      smp[3] = 3000;
      run("ch3_pend", 3000);
      #2 rst_n = 0;
      #1 model_reset();
      check_outs("async_rst");
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < N; i++) smp[i] = 1000;
      cyc("rearm");
      smp[3] = 3000;
      run("ch3_fresh", TRIP - 1);
      chk("ch3.fresh_no_trip", 32'(current_high[3]), 32'd0);
      cyc("ch3_fresh_trip");
      chk("ch3.fresh_trip", 32'(current_high[3]), 32'd1);

      // Random mix around the thresholds; channel 0 biased to long over runs.
      for (int k = 0; k < 6000; k++) begin
         vld = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < N; i++) begin
            if (i == 0 && $urandom_range(0, 199) != 0) smp[i] = $urandom_range(2501, 4095);
            else smp[i] = pick[$urandom_range(0, 6)];
            fclr[i] = ($urandom_range(0, 15) == 0);
         end
         cyc("rand");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
